// File: rtl/cnt_share_sched_if.sv
// rtl/cnt_share_sched_if.sv - request/enable and counter-status bundle for cnt_share_sched
interface cnt_share_sched_if #(
    parameter int NREQ = 4,
    parameter int CW   = 3
);
    logic [NREQ-1:0]    REQ;
    logic [NREQ*CW-1:0] TERM;
    logic               ABORT;
    logic [NREQ-1:0]    GNT;
    logic [CW-1:0]      CNT;
    logic               BUSY;
    logic               DONE;
    logic               KILL;
    logic [2:0]         OWNER;

    modport master (
        output REQ, TERM, ABORT,
        input  GNT, CNT, BUSY, DONE, KILL, OWNER
    );

    modport slave (
        input  REQ, TERM, ABORT,
        output GNT, CNT, BUSY, DONE, KILL, OWNER
    );
endinterface

// File: rtl/cnt_share_sched.sv
// rtl/cnt_share_sched.sv - round-robin owner of a shared modulo up-counter
module cnt_share_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 3,
    parameter int WDOG = 7
) (
    input  logic              CLK,
    input  logic              RST,
    cnt_share_sched_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     term_q, term_d;
    logic [2:0]        owner_q, owner_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [7:0]        wd_q, wd_d;
    logic              done_q, done_d;
    logic              kill_q, kill_d;

    logic [7:0]        req_pad;
    logic [CW-1:0]     term_arr [8];
    logic              sel_found;
    logic [2:0]        sel_idx;
    logic [3:0]        cand;
    logic              own_en;
    logic              at_term;
    logic              wd_hit;

    // Widen the request vector to 8 bits so a 3-bit index is always in range.
    assign req_pad = 8'(bus.REQ);

    // Unpack terminal values; unused slots read as zero.
    for (genvar i = 0; i < 8; i++) begin : g_term
        if (i < NREQ) begin : g_used
            assign term_arr[i] = bus.TERM[i*CW +: CW];
        end else begin : g_unused
            assign term_arr[i] = '0;
        end
    end

    assign own_en  = req_pad[owner_q];
    assign at_term = (cnt_q == term_q);
    assign wd_hit  = ((wd_q + 8'd1) == 8'(WDOG));

    // Round-robin search: nearest set request after the pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (req_pad[cand[2:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[2:0];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            term_q  <= '0;
            owner_q <= '0;
            ptr_q   <= 3'(NREQ - 1);
            wd_q    <= '0;
            done_q  <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            term_q  <= term_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            kill_q  <= kill_d;
        end
    end

    // Next state: abort beats terminal, terminal beats watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (sel_found) state_d = S_RUN;
            S_RUN: begin
                if (bus.ABORT)                state_d = S_END;
                else if (own_en && at_term)   state_d = S_END;
                else if (!own_en && wd_hit)   state_d = S_END;
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next register values for grant, counter, watchdog and end pulses.
    always_comb begin
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        term_d  = term_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        done_d  = 1'b0;
        kill_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                    owner_d = sel_idx;
                    term_d  = term_arr[sel_idx];
                    cnt_d   = '0;
                    wd_d    = '0;
                end
            end
            S_RUN: begin
                if (state_d == S_END) begin
                    gnt_d  = '0;
                    cnt_d  = '0;
                    wd_d   = '0;
                    done_d = !bus.ABORT && own_en && at_term;
                    kill_d = !(!bus.ABORT && own_en && at_term);
                end else if (own_en) begin
                    cnt_d = cnt_q + CW'(1);
                    wd_d  = '0;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            S_END: ptr_d = owner_q;
            default: ;
        endcase
    end

    assign bus.GNT   = gnt_q;
    assign bus.CNT   = cnt_q;
    assign bus.BUSY  = (state_q == S_RUN);
    assign bus.DONE  = done_q;
    assign bus.KILL  = kill_q;
    assign bus.OWNER = owner_q;
endmodule

// File: tb/tb_cnt_share_sched.sv
// tb/tb_cnt_share_sched.sv - randomized and directed bench for cnt_share_sched
module tb_cnt_share_sched;
    localparam int NREQ = 4;
    localparam int CW   = 3;
    localparam int WDOG = 7;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 CLK = ~CLK;

    cnt_share_sched_if #(.NREQ(NREQ), .CW(CW)) bus ();

    cnt_share_sched #(.NREQ(NREQ), .CW(CW), .WDOG(WDOG)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Reference: -1 means no window open; a pending pulse marks the END cycle.
    int m_act, m_cnt, m_term, m_pause, m_ptr, m_last;
    bit m_done, m_kill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = -1; m_cnt = 0; m_term = 0; m_pause = 0;
        m_ptr = NREQ - 1; m_last = 0; m_done = 0; m_kill = 0;
    endtask

    task automatic model_step();
        bit ending;
        bit found;
        ending = m_done || m_kill;
        m_done = 0;
        m_kill = 0;
        if (ending) begin
            m_ptr = m_last;
        end else if (m_act < 0) begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (!found && bus.REQ[c]) begin
                    found   = 1;
                    m_act   = c;
                    m_last  = c;
                    m_term  = int'(bus.TERM >> (c * CW)) & ((1 << CW) - 1);
                    m_cnt   = 0;
                    m_pause = 0;
                end
            end
        end else if (bus.ABORT) begin
            m_kill = 1; m_act = -1; m_cnt = 0;
        end else if (bus.REQ[m_act]) begin
            if (m_cnt == m_term) begin
                m_done = 1; m_act = -1; m_cnt = 0;
            end else begin
                m_cnt   = (m_cnt + 1) % (1 << CW);
                m_pause = 0;
            end
        end else begin
            m_pause++;
            if (m_pause == WDOG) begin
                m_kill = 1; m_act = -1; m_cnt = 0;
            end
        end
    endtask

    // Advance the reference on every edge and compare just after it.
    always @(posedge CLK) begin
        logic [NREQ-1:0] eg;
        if (RST) model_reset();
        else     model_step();
        #1;
        if (chk_en) begin
            eg = '0;
            if (m_act >= 0) eg[m_act] = 1'b1;
            check("gnt",   32'(bus.GNT),   32'(eg));
            check("cnt",   32'(bus.CNT),   32'(m_cnt));
            check("busy",  32'(bus.BUSY),  32'(m_act >= 0));
            check("done",  32'(bus.DONE),  32'(m_done));
            check("kill",  32'(bus.KILL),  32'(m_kill));
            check("owner", 32'(bus.OWNER), 32'(m_last));
            check("onehot", 32'($countones(bus.GNT) <= 1), 32'd1);
            check("gnt_vs_pulse", 32'((bus.GNT != 0) && (bus.DONE || bus.KILL)), 32'd0);
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; bus.REQ = '0; bus.ABORT = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic drain();
        bus.REQ = '0; bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        tick();
        tick();
        check("drain_idle", 32'(bus.BUSY), 32'd0);
    endtask

    task automatic wait_cnt(input int v);
        int g = 0;
        while (bus.CNT != CW'(v) && g < 40) begin tick(); g++; end
        check("wait_cnt", 32'(bus.CNT), 32'(v));
    endtask

    task automatic wait_gnt();
        int g = 0;
        while (bus.GNT == 0 && g < 40) begin tick(); g++; end
        check("wait_gnt", 32'(bus.GNT != 0), 32'd1);
    endtask

    // Counts GNT-high cycles; returns at the first GNT-low negedge.
    task automatic measure(output int len, output int maxc);
        int g = 0;
        len = 0; maxc = 0;
        while (bus.GNT != 0 && g < 40) begin
            len++;
            if (int'(bus.CNT) > maxc) maxc = int'(bus.CNT);
            tick(); g++;
        end
    endtask

    initial begin
        int len, maxc;
        RST = 1'b1; bus.REQ = '0; bus.TERM = '0; bus.ABORT = 1'b0;
        tick();
        tick();
        check("rst_gnt",   32'(bus.GNT),   32'd0);
        check("rst_cnt",   32'(bus.CNT),   32'd0);
        check("rst_busy",  32'(bus.BUSY),  32'd0);
        check("rst_done",  32'(bus.DONE),  32'd0);
        check("rst_kill",  32'(bus.KILL),  32'd0);
        check("rst_owner", 32'(bus.OWNER), 32'd0);
        RST = 1'b0;
        chk_en = 1'b1;

        // Single requester, terminal 5.
        bus.TERM[0 +: CW] = 3'd5;
        bus.REQ = 4'b0001;
        tick();
        for (int c = 0; c <= 5; c++) begin
            check("t1_gnt", 32'(bus.GNT), 32'd1);
            check("t1_cnt", 32'(bus.CNT), 32'(c));
            tick();
        end
        check("t1_done",  32'(bus.DONE),  32'd1);
        check("t1_owner", 32'(bus.OWNER), 32'd0);
        check("t1_cnt0",  32'(bus.CNT),   32'd0);
        check("t1_gnt0",  32'(bus.GNT),   32'd0);
        tick();
        check("t1_gap",   32'(bus.GNT),   32'd0);
        tick();
        check("t1_regnt", 32'(bus.GNT),   32'd1);
        drain();

        // Round-robin with all terminals 1.
        do_reset();
        bus.TERM = {4{3'd1}};
        bus.REQ = 4'b1111;
        for (int w = 0; w < 4; w++) begin
            wait_gnt();
            check("rr_gnt", 32'(bus.GNT), 32'(1 << w));
            measure(len, maxc);
            check("rr_len",   32'(len),        32'd2);
            check("rr_done",  32'(bus.DONE),   32'd1);
            check("rr_owner", 32'(bus.OWNER),  32'(w));
        end
        wait_gnt();
        check("rr_wrap", 32'(bus.GNT), 32'd1);
        drain();

        // Watchdog: 7 paused cycles kill the window at CNT=3.
        do_reset();
        bus.TERM[2*CW +: CW] = 3'd6;
        bus.REQ = 4'b0100;
        wait_cnt(3);
        bus.REQ = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("wd_hold", 32'(bus.CNT),  32'd3);
            check("wd_busy", 32'(bus.BUSY), 32'd1);
        end
        tick();
        check("wd_kill",  32'(bus.KILL),  32'd1);
        check("wd_owner", 32'(bus.OWNER), 32'd2);
        check("wd_cnt",   32'(bus.CNT),   32'd0);

        // Six paused cycles then resume: runs to DONE.
        tick();
        bus.REQ = 4'b0100;
        wait_cnt(3);
        bus.REQ = '0;
        repeat (6) tick();
        check("wd6_busy", 32'(bus.BUSY), 32'd1);
        bus.REQ = 4'b0100;
        measure(len, maxc);
        check("wd6_done", 32'(bus.DONE), 32'd1);
        check("wd6_max",  32'(maxc),     32'd6);
        drain();

        // ABORT at CNT=4, then ABORT in IDLE.
        bus.TERM[0 +: CW] = 3'd6;
        bus.REQ = 4'b0001;
        wait_cnt(4);
        bus.ABORT = 1'b1;
        tick();
        check("ab_kill", 32'(bus.KILL), 32'd1);
        check("ab_done", 32'(bus.DONE), 32'd0);
        check("ab_cnt",  32'(bus.CNT),  32'd0);
        bus.ABORT = 1'b0; bus.REQ = '0;
        tick();
        tick();
        bus.ABORT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ab_idle", 32'(bus.KILL || bus.DONE || bus.BUSY), 32'd0);
        end
        bus.ABORT = 1'b0;

        // Terminal 0 and terminal 2^CW-1.
        bus.TERM[1*CW +: CW] = 3'd0;
        bus.REQ = 4'b0010;
        wait_gnt();
        measure(len, maxc);
        bus.REQ = '0;
        check("t0_len",  32'(len),      32'd1);
        check("t0_done", 32'(bus.DONE), 32'd1);
        tick();
        bus.TERM[3*CW +: CW] = 3'd7;
        bus.REQ = 4'b1000;
        wait_gnt();
        measure(len, maxc);
        bus.REQ = '0;
        check("t7_len",  32'(len),      32'd8);
        check("t7_max",  32'(maxc),     32'd7);
        check("t7_done", 32'(bus.DONE), 32'd1);
        tick();

        // Asynchronous reset mid-window.
        bus.TERM[0 +: CW] = 3'd6;
        bus.REQ = 4'b0001;
        wait_cnt(3);
        #2;
        RST = 1'b1;
        #1;
        check("ar_gnt",   32'(bus.GNT),   32'd0);
        check("ar_cnt",   32'(bus.CNT),   32'd0);
        check("ar_busy",  32'(bus.BUSY),  32'd0);
        check("ar_pulse", 32'(bus.DONE || bus.KILL), 32'd0);
        check("ar_owner", 32'(bus.OWNER), 32'd0);
        tick();
        bus.REQ = 4'b1111;
        RST = 1'b0;
        wait_gnt();
        check("ar_first", 32'(bus.GNT), 32'd1);
        drain();

        // Randomized traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.REQ = NREQ'($urandom);
            bus.TERM  = (NREQ*CW)'($urandom);
            bus.ABORT = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnt_share_sched.md
# cnt_share_sched

Round-robin scheduler that shares one modulo up-counter among several requesters. Each requester asks for a counting window, and the block grants the counter to one requester at a time. The granted requester's own REQ line then acts as the count enable, until the count reaches that requester's terminal value. The block sits between the request/enable sources and the shared counter datapath, and owns the counter register itself.

## Interface
- NREQ, 4: number of requesters (2..8).
- CW, 3: counter width in bits.
- WDOG, 7: consecutive paused cycles that force a release (1..255).

- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  NREQ  per-requester request; while granted, also the count enable.
- TERM  in  NREQ*CW  packed terminal values; slice i = TERM[i*CW +: CW].
- ABORT  in  1  global clear; cancels the current window.
- GNT  out  NREQ  one-hot grant, registered.
- CNT  out  CW  shared counter value, registered.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-cycle pulse; the window reached its terminal value.
- KILL  out  1  one-cycle pulse; the window ended by ABORT or watchdog.
- OWNER  out  3  index of the current or last-ended grant; valid with GNT/DONE/KILL.

## Operation
- Clock and reset:
  - One clock (CLK).
  - Reset is asynchronous and active-high (RST).
  - Reset values: state IDLE; GNT=0, CNT=0, BUSY=0, DONE=0, KILL=0, OWNER=0, round-robin pointer=NREQ-1, watchdog=0.
- States: IDLE, RUN, END.
- IDLE:
  - If any REQ bit is high, select the first set bit searching upward from pointer+1 with wrap-around.
  - Latch the selected TERM slice into term_q.
  - Set GNT one-hot, OWNER to the selected index, CNT=0, watchdog=0.
  - Go to RUN.
  - ABORT in IDLE has no effect.
- RUN (priority order at each edge):
  - ABORT=1: go to END with KILL=1.
  - REQ[OWNER]=1 and CNT==term_q: go to END with DONE=1.
  - REQ[OWNER]=1 and CNT!=term_q: CNT <= CNT+1, watchdog=0.
  - REQ[OWNER]=0: CNT holds and watchdog increments.
    - If the watchdog reaches WDOG, go to END with KILL=1.
- END:
  - GNT=0, BUSY=0, CNT=0.
  - DONE or KILL is high for exactly this cycle.
  - Pointer <= OWNER.
  - Unconditionally go to IDLE next cycle.
- Arithmetic and width:
  - CNT increments modulo 2^CW, but never passes term_q, because the terminal compare is checked first.
  - term_q=0 ends the window on the first enabled RUN cycle.
  - term_q = 2^CW-1 is legal.
- REQ bits of non-owners are ignored during RUN/END and stay pending.
- TERM changes after the grant do not affect the active window.
- Reset asserted mid-window:
  - All outputs go to reset values immediately.
  - No DONE or KILL pulse is produced.

## Timing
- Request to grant:
  - REQ sampled high in IDLE at edge t: GNT, BUSY and OWNER are valid after edge t; CNT=0.
  - Latency is one cycle.
- Window length with REQ held continuously and terminal value T: GNT is high for T+1 cycles.
- End of window:
  - DONE/KILL is high in the cycle after the last RUN cycle, together with GNT=0.
  - The next grant appears one cycle after END.
  - Minimum gap between windows is 2 cycles with GNT low (END, IDLE).
- ABORT sampled in RUN at edge t: KILL pulses after edge t; CNT=0 at the same time.
- Watchdog:
  - KILL fires on the edge where the WDOG-th consecutive paused cycle is sampled.
  - A single enabled cycle clears the watchdog.
- GNT and DONE/KILL are never high in the same cycle.
- At most one GNT bit is high in any cycle.

## Test plan
- Single requester, REQ[0] held, TERM slice 0 = 5:
  - GNT=0001 for 6 cycles.
  - CNT goes 0,1,2,3,4,5.
  - Then DONE=1 with OWNER=0, CNT=0.
  - GNT is regranted 2 cycles after DONE.
- Round-robin, REQ=1111 held, all TERM slices = 1:
  - Grant order 0,1,2,3,0.
  - Each grant lasts 2 cycles.
  - DONE pulses with OWNER 0,1,2,3.
- Pause and watchdog, WDOG=7, TERM=6:
  - REQ[2] high 3 cycles, then low 7 cycles.
  - CNT holds at 3.
  - KILL=1 with OWNER=2 after the 7th low cycle.
  - A low run of 6 cycles followed by REQ high continues counting to DONE.
- ABORT:
  - Assert ABORT when CNT=4 (TERM=6): KILL next cycle, CNT=0, no DONE.
  - ABORT in IDLE: no pulse.
- Edge terminal values:
  - TERM=0: GNT for 1 cycle, then DONE.
  - TERM=7 (CW=3): CNT reaches 7, DONE, no wrap to 0 while GNT is high.
- RST asserted mid-window at CNT=3:
  - All outputs are 0 asynchronously, with no DONE/KILL.
  - After release, grant order restarts at requester 0.
